// File: rtl/fetch_unit_if.sv
// Fetch unit bus: redirect, instruction-memory port and decode-side queue head.
// master = fetch unit side, slave = surrounding core / memory side.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_status;
    logic [31:0] imem_addr;
    logic        imem_stall;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    modport master (
        input  redirect_valid, redirect_pc, out_ready,
        input  imem_rdata, imem_status,
        output imem_addr, imem_stall,
        output out_valid, out_inst, out_pc, fetch_count
    );

    modport slave (
        output redirect_valid, redirect_pc, out_ready,
        output imem_rdata, imem_status,
        input  imem_addr, imem_stall,
        input  out_valid, out_inst, out_pc, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, memory response capture into a small
// queue, redirect flush. Ports: clk, rst (sync, active-high), bus (master).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int PW = 2;
    localparam int CW = 3;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);
    localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_cnt;
    logic [31:0]   q_pc   [4];
    logic [31:0]   q_inst [4];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          unused_rpc;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign unused_rpc = ^bus.redirect_pc[1:0];

    assign empty = (count == '0);
    assign full  = (count == FULL);
    assign pop   = !rst && !empty && bus.out_ready;
    // A full queue that pops this cycle still frees a slot for the response.
    assign push  = !rst && !bus.redirect_valid &&
                   (bus.imem_status == 2'd2) && (!full || pop);

    assign bus.imem_stall  = rst || bus.redirect_valid || full;
    assign bus.imem_addr   = fetch_pc;
    assign bus.fetch_count = fetch_cnt;
    assign bus.out_valid   = !rst && !empty;
    assign bus.out_pc      = bus.out_valid ? q_pc[head]   : '0;
    assign bus.out_inst    = bus.out_valid ? q_inst[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            fetch_cnt <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                head <= next_ptr(head);
            end
            if (push) begin
                tail      <= next_ptr(tail);
                fetch_pc  <= fetch_pc + 32'd4;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]   <= fetch_pc;
            q_inst[tail] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, queue scoreboard,
// table-driven reset/latency/backpressure vectors, directed redirect cases.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'hBFC0_0000;
    localparam int QD = 2;
    localparam int W  = 6;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        int          ncyc;
        logic        rst;
        logic        rdy;
        logic        valid;
        logic [31:0] pc;
        logic        stall;
        logic [31:0] fcnt;
        logic [31:0] addr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    ent_t        sbq[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_cnt = '0;
    bit          live = 1'b0;
    bit          manual = 1'b0;
    int          mcnt = 0;
    vec_t        tbl[11];
    logic [31:0] fc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock: drive memory, check against the scoreboard at the falling
    // edge, advance the model for the coming rising edge.
    task automatic cyc();
        bit   pop;
        bit   push;
        bit   ev;
        ent_t e;
        if (!manual) begin
            bus.imem_status = (mcnt == 0) ? 2'd0 :
                              (mcnt == W) ? 2'd2 :
                              (mcnt == 3) ? 2'd3 : 2'd1;
        end
        bus.imem_rdata = (bus.imem_status == 2'd2) ?
                         inst_of(bus.imem_addr) : 32'hDEAD_BEEF;
        @(negedge clk);
        if (live) begin
            ev = !rst && (sbq.size() != 0);
            chk1("sb_stall", bus.imem_stall,
                 rst || bus.redirect_valid || (sbq.size() == QD));
            chk1("sb_valid", bus.out_valid, ev);
            chk("sb_addr", bus.imem_addr, m_pc);
            chk("sb_fcnt", bus.fetch_count, m_cnt);
            if (ev) begin
                chk("sb_pc", bus.out_pc, sbq[0].pc);
                chk("sb_inst", bus.out_inst, sbq[0].inst);
            end else begin
                chk("sb_pc0", bus.out_pc, 32'h0);
                chk("sb_inst0", bus.out_inst, 32'h0);
            end
        end
        if (rst) begin
            sbq.delete();
            m_pc  = RPC;
            m_cnt = '0;
            live  = 1'b1;
        end else if (bus.redirect_valid) begin
            sbq.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            pop  = (sbq.size() != 0) && bus.out_ready;
            push = (bus.imem_status == 2'd2) && ((sbq.size() < QD) || pop);
            if (pop) begin
                void'(sbq.pop_front());
            end
            if (push) begin
                e.pc   = m_pc;
                e.inst = inst_of(m_pc);
                sbq.push_back(e);
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (!manual) begin
            mcnt = bus.imem_stall ? 0 : ((mcnt == W) ? 0 : mcnt + 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int maxc);
        int n = 0;
        while (!bus.out_valid && n < maxc) begin
            cyc();
            n++;
        end
        vectors++;
        if (!bus.out_valid) begin
            miscompares++;
            $display("FAIL %s: out_valid got 0 after %0d cycles, expected 1",
                     name, maxc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;
        bus.imem_status    = 2'd0;
        bus.imem_rdata     = '0;

        // ncyc, rst, rdy, valid, pc, stall, fcnt, addr
        tbl[0]  = '{2,  1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'd0, RPC};
        tbl[1]  = '{7,  1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'd1, 32'hBFC0_0004};
        tbl[2]  = '{1,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'd1, 32'hBFC0_0004};
        tbl[3]  = '{6,  1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'd2, 32'hBFC0_0008};
        tbl[4]  = '{2,  1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'd0, RPC};
        tbl[5]  = '{7,  1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'd1, 32'hBFC0_0004};
        tbl[6]  = '{7,  1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 1'b1, 32'd2, 32'hBFC0_0008};
        tbl[7]  = '{10, 1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 1'b1, 32'd2, 32'hBFC0_0008};
        tbl[8]  = '{1,  1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'd2, 32'hBFC0_0008};
        tbl[9]  = '{1,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'd2, 32'hBFC0_0008};
        tbl[10] = '{6,  1'b0, 1'b1, 1'b1, 32'hBFC0_0008, 1'b0, 32'd3, 32'hBFC0_000C};

        for (int i = 0; i < 11; i++) begin
            rst           = tbl[i].rst;
            bus.out_ready = tbl[i].rdy;
            repeat (tbl[i].ncyc) cyc();
            chk1($sformatf("v%0d_valid", i), bus.out_valid, tbl[i].valid);
            chk($sformatf("v%0d_pc", i), bus.out_pc, tbl[i].pc);
            chk1($sformatf("v%0d_stall", i), bus.imem_stall, tbl[i].stall);
            chk($sformatf("v%0d_fcnt", i), bus.fetch_count, tbl[i].fcnt);
            chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].addr);
        end

        // Redirect with one queued entry and memory busy.
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0040_0013;
        #1;
        chk1("redir_stall", bus.imem_stall, 1'b1);
        cyc();
        bus.redirect_valid = 1'b0;
        chk1("redir_flush", bus.out_valid, 1'b0);
        chk("redir_addr", bus.imem_addr, 32'h0040_0010);
        chk("redir_fcnt", bus.fetch_count, 32'd3);
        bus.out_ready = 1'b1;
        wait_valid("redir_wait", 20);
        chk("redir_pc", bus.out_pc, 32'h0040_0010);
        chk("redir_inst", bus.out_inst, inst_of(32'h0040_0010));

        // Redirect coinciding with a data-valid response.
        manual             = 1'b1;
        fc                 = m_cnt;
        bus.imem_status    = 2'd2;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_1002;
        cyc();
        bus.redirect_valid = 1'b0;
        bus.imem_status    = 2'd0;
        chk("rdrsp_fcnt", bus.fetch_count, fc);
        chk1("rdrsp_valid", bus.out_valid, 1'b0);
        chk("rdrsp_addr", bus.imem_addr, 32'h0000_1000);
        bus.imem_status = 2'd2;
        cyc();
        bus.imem_status = 2'd0;
        chk1("rdrsp_valid2", bus.out_valid, 1'b1);
        chk("rdrsp_pc", bus.out_pc, 32'h0000_1000);
        chk("rdrsp_fcnt2", bus.fetch_count, fc + 32'd1);

        // Full queue: pop and response in the same cycle.
        bus.out_ready   = 1'b0;
        bus.imem_status = 2'd2;
        cyc();
        bus.imem_status = 2'd0;
        chk1("full_stall", bus.imem_stall, 1'b1);
        chk("full_head", bus.out_pc, 32'h0000_1000);
        bus.out_ready   = 1'b1;
        bus.imem_status = 2'd2;
        cyc();
        bus.imem_status = 2'd0;
        chk1("fpp_stall", bus.imem_stall, 1'b1);
        chk("fpp_head", bus.out_pc, 32'h0000_1004);
        chk("fpp_fcnt", bus.fetch_count, fc + 32'd3);
        cyc();
        chk("fpp_tail_pc", bus.out_pc, 32'h0000_1008);
        chk("fpp_tail_inst", bus.out_inst, inst_of(32'h0000_1008));
        cyc();
        chk1("fpp_empty", bus.out_valid, 1'b0);

        // One-cycle reset in the middle of a stream.
        manual = 1'b0;
        mcnt   = 0;
        wait_valid("stream_wait", 20);
        bus.out_ready = 1'b0;
        repeat (8) cyc();
        rst = 1'b1;
        #1;
        chk1("mrst_valid", bus.out_valid, 1'b0);
        chk("mrst_pc", bus.out_pc, 32'h0);
        chk("mrst_inst", bus.out_inst, 32'h0);
        chk1("mrst_stall", bus.imem_stall, 1'b1);
        cyc();
        rst = 1'b0;
        chk("mrst_fcnt", bus.fetch_count, 32'd0);
        chk("mrst_addr", bus.imem_addr, RPC);
        chk1("mrst_valid2", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        wait_valid("mrst_wait", 20);
        chk("mrst_first_pc", bus.out_pc, RPC);
        chk("mrst_first_inst", bus.out_inst, inst_of(RPC));
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
